// File: rtl/ramlinetaps.sv
// ramlinetaps: multi-tap line delay; taps are vertically aligned samples 0..TAPS_P-1 lines back.
// Ports: clk_i, rstn_i, clear_i, line_len_i, valid_i/ready_o/data_i in, valid_o/ready_i/data_o/tap_valid_o out.
// Optional macro RAMLINETAPS_ZERO_FILL_EN: emit every beat, zero-fill taps not yet primed.
module ramlinetaps #(
  parameter int WIDTH_P   = 8,
  parameter int TAPS_P    = 3,
  parameter int MAX_LEN_P = 640
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          clear_i,
  input  logic [$clog2(MAX_LEN_P+1)-1:0] line_len_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [WIDTH_P-1:0]            data_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [TAPS_P*WIDTH_P-1:0]     data_o,
  output logic [TAPS_P-1:0]             tap_valid_o
);

  localparam int LW = $clog2(MAX_LEN_P+1);
  localparam int PW = (MAX_LEN_P > 1) ? $clog2(MAX_LEN_P) : 1;
  localparam int FW = $clog2(TAPS_P);
  localparam int MW = (TAPS_P-1)*WIDTH_P;
  localparam int OW = TAPS_P*WIDTH_P;
  localparam logic [FW-1:0] FILL_MAX = FW'(TAPS_P-1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN_P);

  logic [MW-1:0]     mem_q [MAX_LEN_P];
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [LW-1:0]     len_q, len_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic              valid_q, valid_d;
  logic [OW-1:0]     data_q, data_d;
  logic [TAPS_P-1:0] tv_q, tv_d;

  logic              accept;
  logic              wrap;
  logic              emit;
  logic [MW-1:0]     rd_word;
  logic [MW-1:0]     wr_word;
  logic [OW-1:0]     cand_data;
  logic [TAPS_P-1:0] cand_tv;

  assign ready_o = (!valid_q | ready_i) & !clear_i;
  assign accept  = valid_i & ready_o;
  assign rd_word = mem_q[ptr_q];
  assign wrap    = (LW'(ptr_q) == (len_q - LW'(1)));

  // Each word holds the column's history; shift it one line older.
  if (TAPS_P > 2) begin : g_shift
    assign wr_word = {rd_word[MW-WIDTH_P-1:0], data_i};
  end else begin : g_noshift
    assign wr_word = data_i;
  end

`ifdef RAMLINETAPS_ZERO_FILL_EN
  assign emit = 1'b1;
`else
  // Only fully primed windows leave the block.
  assign emit = (fill_q == FILL_MAX);
`endif

  always_comb begin
    cand_data = '0;
    cand_tv   = '0;
    cand_data[WIDTH_P-1:0] = data_i;
    cand_tv[0] = 1'b1;
    for (int k = 1; k < TAPS_P; k++) begin
      cand_tv[k] = (FW'(k) <= fill_q);
      cand_data[k*WIDTH_P +: WIDTH_P] =
        rd_word[(k-1)*WIDTH_P +: WIDTH_P];
`ifdef RAMLINETAPS_ZERO_FILL_EN
      // Stale memory from before a clear is masked here.
      if (!cand_tv[k]) begin
        cand_data[k*WIDTH_P +: WIDTH_P] = '0;
      end
`endif
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    len_d   = len_q;
    fill_d  = fill_q;
    valid_d = valid_q;
    data_d  = data_q;
    tv_d    = tv_q;
    if (clear_i) begin
      ptr_d   = '0;
      fill_d  = '0;
      valid_d = 1'b0;
      if (line_len_i == '0 || line_len_i > LEN_MAX) begin
        len_d = LEN_MAX;
      end else begin
        len_d = line_len_i;
      end
    end else begin
      if (accept) begin
        ptr_d = wrap ? '0 : ptr_q + 1'b1;
        if (wrap && fill_q != FILL_MAX) begin
          fill_d = fill_q + 1'b1;
        end
      end
      if (accept && emit) begin
        valid_d = 1'b1;
        data_d  = cand_data;
        tv_d    = cand_tv;
      end else if (valid_q && ready_i) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr_q   <= '0;
      len_q   <= LEN_MAX;
      fill_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      tv_q    <= '0;
    end else begin
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      tv_q    <= tv_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem_q[ptr_q] <= wr_word;
    end
  end

  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign tap_valid_o = tv_q;

endmodule
